// File: rtl/chunked_seq_adder_if.sv
// Handshake and operand bus for chunked_seq_adder.
//   start/mode/A/B : requester -> adder (new operation request and operands)
//   busy/done      : adder -> requester (operation status)
//   sum/overflow   : adder -> requester (last completed result)
interface chunked_seq_adder_if #(
  parameter int WIDTH = 24
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   sum;
  logic             overflow;

  modport master (output start, mode, A, B, input busy, done, sum, overflow);
  modport slave  (input start, mode, A, B, output busy, done, sum, overflow);
endinterface

// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder / subtractor / accumulator that adds CHUNK bits per clock
// with a registered carry between chunks.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : chunked_seq_adder_if.slave (start, mode, A, B, busy, done, sum, overflow)
// Modes: 00 A+B, 01 A-B, 10 acc+A, 11 clear acc.
//
// state  | meaning
// IDLE   | waiting for start, busy=0
// RUN    | adding chunk cnt_q, busy=1, N cycles
// DONE   | result presented, done=1 for one cycle, accepts a new start
module chunked_seq_adder #(
  parameter int WIDTH = 24,
  parameter int CHUNK = 6
) (
  input  logic              clk,
  input  logic              reset,
  chunked_seq_adder_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] x_q, y_q, shadow_q, acc_q;
  logic [WIDTH:0]   sum_q;
  logic             ovf_q;

  logic             accept;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] res;

  // start is only looked at while not busy (IDLE or DONE)
  assign accept = bus.start && (state_q != S_RUN);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept)               state_d = (bus.mode == 2'b11) ? S_DONE : S_RUN;
        else if (state_q == S_DONE) state_d = S_IDLE;
      end
      S_RUN:   if (cnt_q == LAST) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == S_RUN);
    bus.done = (state_q == S_DONE);
  end

  // res is the shadow register with the current chunk merged in; on the last
  // RUN cycle it is the complete result.
  always_comb begin
    chunk_sum = {1'b0, x_q[cnt_q*CHUNK +: CHUNK]} + {1'b0, y_q[cnt_q*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
    res = shadow_q;
    res[cnt_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      mode_q   <= 2'b00;
      x_q      <= '0;
      y_q      <= '0;
      shadow_q <= '0;
      acc_q    <= '0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      mode_q   <= bus.mode;
      cnt_q    <= '0;
      shadow_q <= '0;
      case (bus.mode)
        2'b00: begin x_q <= bus.A; y_q <= bus.B;  carry_q <= 1'b0; end
        2'b01: begin x_q <= bus.A; y_q <= ~bus.B; carry_q <= 1'b1; end
        2'b10: begin x_q <= acc_q; y_q <= bus.A;  carry_q <= 1'b0; end
        default: begin
          // clear goes straight to DONE, so its results land on this edge
          acc_q <= '0;
          sum_q <= '0;
          ovf_q <= 1'b0;
        end
      endcase
    end else if (state_q == S_RUN) begin
      carry_q  <= chunk_sum[CHUNK];
      shadow_q <= res;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        sum_q <= {chunk_sum[CHUNK], res};
        ovf_q <= (x_q[WIDTH-1] == y_q[WIDTH-1]) && (res[WIDTH-1] != x_q[WIDTH-1]);
        if (mode_q == 2'b10) acc_q <= res;
      end
    end
  end

  assign bus.sum      = sum_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_chunked_seq_adder.sv
module tb_chunked_seq_adder;
  localparam int N1 = 4;
  localparam int N2 = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  chunked_seq_adder_if #(.WIDTH(24)) bus1 ();
  chunked_seq_adder_if #(.WIDTH(12)) bus2 ();

  chunked_seq_adder #(.WIDTH(24), .CHUNK(6))  dut1 (.clk(clk), .reset(reset), .bus(bus1));
  chunked_seq_adder #(.WIDTH(12), .CHUNK(12)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  typedef struct {
    logic [24:0] sum;
    logic        ovf;
    int          cyc;
    int          nbusy;
    string       name;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Monitors: pop and compare whenever a DUT pulses done.
  int run1 = 0;
  exp_t e1;
  always @(negedge clk) begin
    if (bus1.busy) run1++;
    else if (!bus1.done) run1 = 0;
    if (bus1.done) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_spurious_done actual=done required=no_done cyc=%0d", cyc);
      end else begin
        e1 = q1.pop_front();
        chk({e1.name, "_sum"},  32'(bus1.sum), 32'(e1.sum));
        chk({e1.name, "_ovf"},  32'(bus1.overflow), 32'(e1.ovf));
        chk({e1.name, "_cyc"},  cyc, e1.cyc);
        chk({e1.name, "_busy"}, run1, e1.nbusy);
      end
      run1 = 0;
    end
  end

  int run2 = 0;
  exp_t e2;
  always @(negedge clk) begin
    if (bus2.busy) run2++;
    else if (!bus2.done) run2 = 0;
    if (bus2.done) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut2_spurious_done actual=done required=no_done cyc=%0d", cyc);
      end else begin
        e2 = q2.pop_front();
        chk({e2.name, "_sum"},  32'(bus2.sum), 32'(e2.sum));
        chk({e2.name, "_ovf"},  32'(bus2.overflow), 32'(e2.ovf));
        chk({e2.name, "_cyc"},  cyc, e2.cyc);
        chk({e2.name, "_busy"}, run2, e2.nbusy);
      end
      run2 = 0;
    end
  end

  // Called just after a negedge; the following posedge is the accepting edge.
  task automatic issue1(input logic [1:0] m, input logic [23:0] a, input logic [23:0] b,
                        input logic [24:0] es, input logic eo, input string nm);
    bus1.start = 1'b1; bus1.mode = m; bus1.A = a; bus1.B = b;
    q1.push_back('{es, eo, cyc + ((m == 2'b11) ? 1 : N1 + 1), (m == 2'b11) ? 0 : N1, nm});
    @(posedge clk); #1;
    bus1.start = 1'b0;
    bus1.mode = 2'($urandom); bus1.A = 24'($urandom); bus1.B = 24'($urandom);
  endtask

  task automatic issue2(input logic [1:0] m, input logic [11:0] a, input logic [11:0] b,
                        input logic [24:0] es, input logic eo, input string nm);
    bus2.start = 1'b1; bus2.mode = m; bus2.A = a; bus2.B = b;
    q2.push_back('{es, eo, cyc + N2 + 1, N2, nm});
    @(posedge clk); #1;
    bus2.start = 1'b0;
    bus2.mode = 2'($urandom); bus2.A = 12'($urandom); bus2.B = 12'($urandom);
  endtask

  task automatic wait_done(input int which, input string nm);
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((which == 1) ? bus1.done : bus2.done) break;
    end
    if (i == 40) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus1.start = 1'b0; bus1.mode = 2'b00; bus1.A = '0; bus1.B = '0;
    bus2.start = 1'b0; bus2.mode = 2'b00; bus2.A = '0; bus2.B = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy1", 32'(bus1.busy), 0);
    chk("rst_done1", 32'(bus1.done), 0);
    chk("rst_sum1",  32'(bus1.sum), 0);
    chk("rst_ovf1",  32'(bus1.overflow), 0);
    chk("rst_busy2", 32'(bus2.busy), 0);
    chk("rst_sum2",  32'(bus2.sum), 0);
    reset = 1'b0;
    @(negedge clk);

    issue1(2'b00, 24'hFFFFFF, 24'h000001, 25'h1000000, 1'b0, "add_carry");  wait_done(1, "add_carry");
    @(negedge clk);
    issue1(2'b01, 24'h000005, 24'h000007, 25'h0FFFFFE, 1'b0, "sub_borrow"); wait_done(1, "sub_borrow");
    issue1(2'b01, 24'h000007, 24'h000005, 25'h1000002, 1'b0, "sub_pos");    wait_done(1, "sub_pos");
    @(negedge clk);
    issue1(2'b00, 24'h7FFFFF, 24'h000001, 25'h0800000, 1'b1, "add_ovf_pos"); wait_done(1, "add_ovf_pos");
    issue1(2'b00, 24'h800000, 24'h800000, 25'h1000000, 1'b1, "add_ovf_neg"); wait_done(1, "add_ovf_neg");
    @(negedge clk);

    issue1(2'b11, 24'h0, 24'h0, 25'h0, 1'b0, "clear");       wait_done(1, "clear");
    issue1(2'b10, 24'd10, 24'h0, 25'd10, 1'b0, "acc10");     wait_done(1, "acc10");
    issue1(2'b10, 24'd20, 24'h0, 25'd30, 1'b0, "acc30");     wait_done(1, "acc30");
    issue1(2'b10, 24'd30, 24'h0, 25'd60, 1'b0, "acc60");     wait_done(1, "acc60");
    issue1(2'b00, 24'd1,  24'd1, 25'd2,  1'b0, "add_1_1");   wait_done(1, "add_1_1");
    issue1(2'b10, 24'd4,  24'h0, 25'd64, 1'b0, "acc64");     wait_done(1, "acc64");
    @(negedge clk);

    // start during RUN must be ignored
    issue1(2'b00, 24'h000100, 24'h000200, 25'h0000300, 1'b0, "add_ign");
    @(negedge clk); @(negedge clk);
    chk("sum_held_in_run", 32'(bus1.sum), 32'd64);
    bus1.start = 1'b1; bus1.mode = 2'b01; bus1.A = 24'hFFFFFF; bus1.B = 24'h000001;
    @(posedge clk); #1 bus1.start = 1'b0;
    wait_done(1, "add_ign");
    @(negedge clk);

    // reset mid-RUN: no done, outputs and acc cleared
    bus1.start = 1'b1; bus1.mode = 2'b00; bus1.A = 24'h000100; bus1.B = 24'h000200;
    @(posedge clk); #1 bus1.start = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus1.busy), 0);
    chk("abort_done", 32'(bus1.done), 0);
    chk("abort_sum",  32'(bus1.sum), 0);
    chk("abort_ovf",  32'(bus1.overflow), 0);
    repeat (8) @(negedge clk);
    issue1(2'b10, 24'd5, 24'h0, 25'd5, 1'b0, "acc_after_abort"); wait_done(1, "acc_after_abort");

    // single-chunk instance
    @(negedge clk);
    issue2(2'b00, 12'hFFF, 12'h001, 25'h1000, 1'b0, "n1_add_carry"); wait_done(2, "n1_add_carry");
    issue2(2'b00, 12'h7FF, 12'h001, 25'h0800, 1'b1, "n1_add_ovf");   wait_done(2, "n1_add_ovf");

    repeat (5) @(negedge clk);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
